dn_router: RTL and testbench

DN_ROUTER -- requirements
Module: dn_router

---
 rtl/dn_pkg.sv | 26 ++
 rtl/dn_skid_fifo.sv | 63 ++++++
 rtl/dn_router.sv | 232 +++++++++++++++++++++++
 tb/tb_dn_router.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dn_pkg
// Description : Shared definitions for the download router: file-slot
//               numbers carried on dn_index, and the session state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dn_pkg;

    // File slots understood by the router; every other index is counted only.
    localparam logic [7:0] IDX_BIOS = 8'd0;
    localparam logic [7:0] IDX_SPR  = 8'd3;
    localparam logic [7:0] IDX_MUS  = 8'd4;

    localparam int          LEN_W   = 25;
    localparam logic [24:0] LEN_MAX = 25'h1FF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } dn_state_e;

endpackage
`default_nettype wire

// File: rtl/dn_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dn_skid_fifo
// Description : Two-entry FIFO with valid/ready on both sides. Entry 0 is
//               always the head, so out_data comes straight from a register
//               and stays stable until it is popped. A push into a full FIFO
//               is accepted when the head pops in the same cycle.
// Ports       : clk_24, reset_n         - clock, synchronous active-low reset
//               in_valid/in_ready/in_data    - write side
//               out_valid/out_ready/out_data - read side (head of queue)
// Revision    : 1.0 - initial release
// ============================================================================
module dn_skid_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk_24,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic [1:0]            count_q, count_d;
    logic                  push, pop;

    always_comb begin
        pop      = (count_q != 2'd0) && out_ready;
        in_ready = (count_q != 2'd2) || out_ready;
        push     = in_valid && in_ready;
        mem_d    = mem_q;
        if (pop) begin
            mem_d[0] = mem_q[1];
        end
        // The new word lands in the first slot that is free after the pop.
        if (push) begin
            if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
                mem_d[0] = in_data;
            end else begin
                mem_d[1] = in_data;
            end
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_24) begin
        if (!reset_n) begin
            mem_q   <= '0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[0];

endmodule
`default_nettype wire

// File: rtl/dn_router.sv
`default_nettype none
// ============================================================================
// Module      : dn_router
// Description : Routes a byte-serial file download to the BIOS ROM, sprite
//               ROM or music RAM write ports according to the slot index
//               latched at the start of the session. Music bytes are paired
//               into 16-bit words and queued in a 2-entry skid FIFO.
// Ports       : clk_24, reset_n              - clock, sync active-low reset
//               dn_download/dn_wr/dn_addr/dn_data/dn_index - download bus
//               bios_wr/bios_addr/bios_data  - BIOS byte write port
//               spr_wr/spr_addr/spr_data     - sprite byte write port
//               mus_req/mus_addr/mus_data/mus_ack - music word handshake
//               hold_reset - high while a BIOS load is in progress
//               overflow   - sticky, a byte or word was dropped this session
//               last_len   - byte count of the last completed session
// Revision    : 1.0 - initial release
// ============================================================================
module dn_router
    import dn_pkg::*;
#(
    parameter int BIOS_AW = 14,
    parameter int SPR_AW  = 15,
    parameter int MUS_AW  = 16
) (
    input  logic               clk_24,
    input  logic               reset_n,
    input  logic               dn_download,
    input  logic               dn_wr,
    input  logic [24:0]        dn_addr,
    input  logic [7:0]         dn_data,
    input  logic [7:0]         dn_index,
    output logic               bios_wr,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic [7:0]         bios_data,
    output logic               spr_wr,
    output logic [SPR_AW-1:0]  spr_addr,
    output logic [7:0]         spr_data,
    output logic               mus_req,
    output logic [MUS_AW-1:0]  mus_addr,
    output logic [15:0]        mus_data,
    input  logic               mus_ack,
    output logic               hold_reset,
    output logic               overflow,
    output logic [24:0]        last_len
);

    localparam int FW = MUS_AW + 16;

    dn_state_e          state_q, state_d;
    logic               dl_prev_q;
    logic [7:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   last_len_q, last_len_d;
    logic               ovf_q, ovf_d;
    logic               half_valid_q, half_valid_d;
    logic [7:0]         half_byte_q, half_byte_d;
    logic [MUS_AW-1:0]  half_addr_q, half_addr_d;
    logic               bios_wr_q, bios_wr_d;
    logic [BIOS_AW-1:0] bios_addr_q, bios_addr_d;
    logic [7:0]         bios_data_q, bios_data_d;
    logic               spr_wr_q, spr_wr_d;
    logic [SPR_AW-1:0]  spr_addr_q, spr_addr_d;
    logic [7:0]         spr_data_q, spr_data_d;

    logic               fifo_in_valid, fifo_in_ready, fifo_out_valid;
    logic [FW-1:0]      fifo_in_data, fifo_out_data;

    logic               bios_in_range, spr_in_range, mus_in_range;

    // Music range is in bytes: MUS_AW word-address bits plus the byte select.
    assign bios_in_range = ((dn_addr >> BIOS_AW) == 25'd0);
    assign spr_in_range  = ((dn_addr >> SPR_AW) == 25'd0);
    assign mus_in_range  = ((dn_addr >> (MUS_AW + 1)) == 25'd0);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        last_len_d    = last_len_q;
        ovf_d         = ovf_q;
        half_valid_d  = half_valid_q;
        half_byte_d   = half_byte_q;
        half_addr_d   = half_addr_q;
        bios_wr_d     = 1'b0;
        bios_addr_d   = bios_addr_q;
        bios_data_d   = bios_data_q;
        spr_wr_d      = 1'b0;
        spr_addr_d    = spr_addr_q;
        spr_data_d    = spr_data_q;
        fifo_in_valid = 1'b0;
        fifo_in_data  = '0;

        case (state_q)
            IDLE: begin
                if (dn_download && !dl_prev_q) begin
                    state_d      = LOAD;
                    idx_d        = dn_index;
                    cnt_d        = '0;
                    ovf_d        = 1'b0;
                    half_valid_d = 1'b0;
                end
            end
            LOAD: begin
                if (dn_wr) begin
                    if (cnt_q != LEN_MAX) begin
                        cnt_d = cnt_q + 25'd1;
                    end
                    case (idx_q)
                        IDX_BIOS: begin
                            if (bios_in_range) begin
                                bios_wr_d   = 1'b1;
                                bios_addr_d = dn_addr[BIOS_AW-1:0];
                                bios_data_d = dn_data;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        IDX_SPR: begin
                            if (spr_in_range) begin
                                spr_wr_d   = 1'b1;
                                spr_addr_d = dn_addr[SPR_AW-1:0];
                                spr_data_d = dn_data;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        IDX_MUS: begin
                            if (!mus_in_range) begin
                                ovf_d = 1'b1;
                            end else if (!dn_addr[0]) begin
                                half_valid_d = 1'b1;
                                half_byte_d  = dn_data;
                                half_addr_d  = dn_addr[MUS_AW:1];
                            end else begin
                                fifo_in_valid = 1'b1;
                                fifo_in_data  = {dn_addr[MUS_AW:1], dn_data, half_byte_q};
                                half_valid_d  = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
                if (!dn_download) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // A pending half-word only exists for the music slot.
                if (half_valid_q) begin
                    fifo_in_valid = 1'b1;
                    fifo_in_data  = {half_addr_q, 8'h00, half_byte_q};
                    half_valid_d  = 1'b0;
                end else if (!fifo_out_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                last_len_d = cnt_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fifo_in_valid && !fifo_in_ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_24) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            dl_prev_q    <= 1'b0;
            idx_q        <= 8'd0;
            cnt_q        <= '0;
            last_len_q   <= '0;
            ovf_q        <= 1'b0;
            half_valid_q <= 1'b0;
            half_byte_q  <= 8'd0;
            half_addr_q  <= '0;
            bios_wr_q    <= 1'b0;
            bios_addr_q  <= '0;
            bios_data_q  <= 8'd0;
            spr_wr_q     <= 1'b0;
            spr_addr_q   <= '0;
            spr_data_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            dl_prev_q    <= dn_download;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            last_len_q   <= last_len_d;
            ovf_q        <= ovf_d;
            half_valid_q <= half_valid_d;
            half_byte_q  <= half_byte_d;
            half_addr_q  <= half_addr_d;
            bios_wr_q    <= bios_wr_d;
            bios_addr_q  <= bios_addr_d;
            bios_data_q  <= bios_data_d;
            spr_wr_q     <= spr_wr_d;
            spr_addr_q   <= spr_addr_d;
            spr_data_q   <= spr_data_d;
        end
    end

    dn_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk_24    (clk_24),
        .reset_n   (reset_n),
        .in_valid  (fifo_in_valid),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in_data),
        .out_valid (fifo_out_valid),
        .out_ready (mus_ack),
        .out_data  (fifo_out_data)
    );

    assign bios_wr    = bios_wr_q;
    assign bios_addr  = bios_addr_q;
    assign bios_data  = bios_data_q;
    assign spr_wr     = spr_wr_q;
    assign spr_addr   = spr_addr_q;
    assign spr_data   = spr_data_q;
    assign mus_req    = fifo_out_valid;
    assign mus_addr   = fifo_out_data[FW-1:16];
    assign mus_data   = fifo_out_data[15:0];
    assign hold_reset = ((state_q == LOAD) || (state_q == FLUSH)) && (idx_q == IDX_BIOS);
    assign overflow   = ovf_q;
    assign last_len   = last_len_q;

endmodule
`default_nettype wire

// File: tb/tb_dn_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_dn_router
// Description : Self-checking bench for dn_router. A queue-based model of the
//               router tracks expected outputs cycle by cycle; directed
//               sessions pin the model with literal results, then randomized
//               sessions exercise all slots, boundaries and ack patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dn_router;

    localparam int BIOS_AW = 14;
    localparam int SPR_AW  = 15;
    localparam int MUS_AW  = 16;

    logic               clk_24      = 1'b0;
    logic               reset_n     = 1'b0;
    logic               dn_download = 1'b0;
    logic               dn_wr       = 1'b0;
    logic [24:0]        dn_addr     = '0;
    logic [7:0]         dn_data     = '0;
    logic [7:0]         dn_index    = '0;
    logic               mus_ack     = 1'b0;
    logic               bios_wr, spr_wr, mus_req, hold_reset, overflow;
    logic [BIOS_AW-1:0] bios_addr;
    logic [SPR_AW-1:0]  spr_addr;
    logic [MUS_AW-1:0]  mus_addr;
    logic [7:0]         bios_data, spr_data;
    logic [15:0]        mus_data;
    logic [24:0]        last_len;

    dn_router #(.BIOS_AW(BIOS_AW), .SPR_AW(SPR_AW), .MUS_AW(MUS_AW)) dut (
        .clk_24(clk_24), .reset_n(reset_n), .dn_download(dn_download),
        .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data), .dn_index(dn_index),
        .bios_wr(bios_wr), .bios_addr(bios_addr), .bios_data(bios_data),
        .spr_wr(spr_wr), .spr_addr(spr_addr), .spr_data(spr_data),
        .mus_req(mus_req), .mus_addr(mus_addr), .mus_data(mus_data), .mus_ack(mus_ack),
        .hold_reset(hold_reset), .overflow(overflow), .last_len(last_len)
    );

    always #5 clk_24 = ~clk_24;

    int n_vec    = 0;
    int n_fail   = 0;
    int ack_mode = 0;   // 0: ack low, 1: ack high, 2: random ack

    // Behavioural model: phase 0 idle, 1 loading, 2 flushing, 3 done.
    int                 m_phase = 0;
    logic [7:0]         m_idx   = '0;
    bit                 m_prev  = 1'b0;
    logic [24:0]        m_cnt   = '0;
    logic [24:0]        m_last  = '0;
    bit                 m_ovf   = 1'b0;
    bit                 m_half  = 1'b0;
    logic [7:0]         m_hbyte = '0;
    logic [15:0]        m_haddr = '0;
    logic [31:0]        m_q[$];          // {word address, word data}
    bit                 e_bios_wr = 1'b0, e_spr_wr = 1'b0;
    logic [BIOS_AW-1:0] e_bios_addr = '0;
    logic [SPR_AW-1:0]  e_spr_addr  = '0;
    logic [7:0]         e_bios_data = '0, e_spr_data = '0;

    // Writes actually produced by the DUT, for literal expectations.
    logic [31:0] bios_log[$], spr_log[$], mus_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_push(input logic [31:0] w);
        if (m_q.size() < 2) m_q.push_back(w);
        else m_ovf = 1'b1;
    endfunction

    // Model update at every active edge, from the inputs alone.
    initial begin
        bit was_empty;
        forever begin
            @(posedge clk_24);
            e_bios_wr = 1'b0;
            e_spr_wr  = 1'b0;
            if (!reset_n) begin
                m_phase = 0; m_idx = '0; m_prev = 1'b0; m_cnt = '0; m_last = '0;
                m_ovf = 1'b0; m_half = 1'b0; m_hbyte = '0; m_haddr = '0;
                m_q.delete();
                e_bios_addr = '0; e_bios_data = '0; e_spr_addr = '0; e_spr_data = '0;
            end else begin
                was_empty = (m_q.size() == 0);
                if (!was_empty && mus_ack) void'(m_q.pop_front());
                case (m_phase)
                    0: if (dn_download && !m_prev) begin
                        m_phase = 1; m_idx = dn_index; m_cnt = '0; m_ovf = 1'b0; m_half = 1'b0;
                    end
                    1: begin
                        if (dn_wr) begin
                            if (m_cnt != 25'h1FF_FFFF) m_cnt = m_cnt + 25'd1;
                            if (m_idx == 8'd0) begin
                                if (dn_addr < 25'd16384) begin
                                    e_bios_wr = 1'b1; e_bios_addr = dn_addr[13:0]; e_bios_data = dn_data;
                                end else m_ovf = 1'b1;
                            end else if (m_idx == 8'd3) begin
                                if (dn_addr < 25'd32768) begin
                                    e_spr_wr = 1'b1; e_spr_addr = dn_addr[14:0]; e_spr_data = dn_data;
                                end else m_ovf = 1'b1;
                            end else if (m_idx == 8'd4) begin
                                if (dn_addr >= 25'h2_0000) m_ovf = 1'b1;
                                else if (!dn_addr[0]) begin
                                    m_half = 1'b1; m_hbyte = dn_data; m_haddr = dn_addr[16:1];
                                end else begin
                                    m_push({dn_addr[16:1], dn_data, m_hbyte});
                                    m_half = 1'b0;
                                end
                            end
                        end
                        if (!dn_download) m_phase = 2;
                    end
                    2: if (m_half) begin
                        m_push({m_haddr, 8'h00, m_hbyte});
                        m_half = 1'b0;
                    end else if (was_empty) m_phase = 3;
                    default: begin
                        m_last  = m_cnt;
                        m_phase = 0;
                    end
                endcase
                m_prev = dn_download;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_24);
            check("bios_wr",   32'(bios_wr),   32'(e_bios_wr));
            check("bios_addr", 32'(bios_addr), 32'(e_bios_addr));
            check("bios_data", 32'(bios_data), 32'(e_bios_data));
            check("spr_wr",    32'(spr_wr),    32'(e_spr_wr));
            check("spr_addr",  32'(spr_addr),  32'(e_spr_addr));
            check("spr_data",  32'(spr_data),  32'(e_spr_data));
            check("mus_req",   32'(mus_req),   32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                check("mus_addr", 32'(mus_addr), 32'(m_q[0][31:16]));
                check("mus_data", 32'(mus_data), 32'(m_q[0][15:0]));
            end
            check("hold_reset", 32'(hold_reset), 32'((m_phase == 1 || m_phase == 2) && m_idx == 8'd0));
            check("overflow",   32'(overflow),   32'(m_ovf));
            check("last_len",   32'(last_len),   32'(m_last));
            if (bios_wr) bios_log.push_back(32'({bios_addr, bios_data}));
            if (spr_wr)  spr_log.push_back(32'({spr_addr, spr_data}));
        end
    end

    // Ack driver and music handshake logger.
    initial begin
        forever begin
            @(negedge clk_24);
            #1;
            mus_ack = (ack_mode == 1) ? 1'b1 : (ack_mode == 2) ? 1'($urandom) : 1'b0;
        end
    end
    initial begin
        forever begin
            @(negedge clk_24);
            #2;
            if (mus_req && mus_ack) mus_log.push_back({mus_addr, mus_data});
        end
    end

    task automatic tick();
        @(negedge clk_24);
        #1;
    endtask

    task automatic start(input logic [7:0] idx);
        dn_index    = idx;
        dn_download = 1'b1;
        tick();
    endtask

    task automatic wbyte(input logic [24:0] a, input logic [7:0] d, input int gap);
        dn_wr = 1'b1; dn_addr = a; dn_data = d;
        tick();
        dn_wr = 1'b0; dn_addr = 25'($urandom); dn_data = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (m_phase != 0 && k < bound) begin
            tick();
            k++;
        end
        n_vec++;
        if (m_phase != 0) begin
            n_fail++;
            $display("FAIL wait_idle: session still open after %0d cycles", bound);
        end
    endtask

    task automatic finish_session(input int bound);
        dn_download = 1'b0;
        tick();
        wait_idle(bound);
        repeat (8) tick();
    endtask

    task automatic clear_logs();
        bios_log.delete(); spr_log.delete(); mus_log.delete();
    endtask

    initial begin
        logic [31:0] exp41 [4];
        int          sel, n;
        logic [7:0]  idx;
        logic [24:0] base;

        exp41 = '{32'h0AA, 32'h1BB, 32'h2CC, 32'h3DD};

        // Reset state
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("rst_flags", 32'({bios_wr, spr_wr, mus_req, hold_reset, overflow}), 32'd0);
        check("rst_len",   32'(last_len), 32'd0);
        check("rst_addrs", 32'(bios_addr) | 32'(spr_addr) | 32'(mus_addr), 32'd0);

        // BIOS load, 4 bytes
        ack_mode = 1; clear_logs();
        start(8'd0);
        check("bios_hold", 32'(hold_reset), 32'd1);
        for (int i = 0; i < 4; i++) wbyte(25'(i), exp41[i][7:0], 1);
        finish_session(50);
        check("bios_cnt", 32'(bios_log.size()), 32'd4);
        if (bios_log.size() == 4)
            for (int i = 0; i < 4; i++) check("bios_word", bios_log[i], exp41[i]);
        check("bios_len",  32'(last_len), 32'd4);
        check("bios_hold_end", 32'(hold_reset), 32'd0);

        // Music, odd length, ack always high
        clear_logs();
        start(8'd4);
        wbyte(25'd0, 8'h11, 0); wbyte(25'd1, 8'h22, 0); wbyte(25'd2, 8'h33, 0);
        finish_session(50);
        check("mus_cnt", 32'(mus_log.size()), 32'd2);
        if (mus_log.size() == 2) begin
            check("mus_w0", mus_log[0], 32'h0000_2211);
            check("mus_w1", mus_log[1], 32'h0001_0033);
        end
        check("mus_len", 32'(last_len), 32'd3);

        // Music with ack held low: third word dropped
        ack_mode = 0; clear_logs();
        start(8'd4);
        for (int i = 0; i < 6; i++) wbyte(25'(i), 8'(i + 1), 0);
        dn_download = 1'b0;
        repeat (5) tick();
        check("full_ovf", 32'(overflow), 32'd1);
        check("full_req", 32'(mus_req), 32'd1);
        ack_mode = 1;
        wait_idle(50);
        repeat (8) tick();
        check("full_cnt", 32'(mus_log.size()), 32'd2);
        if (mus_log.size() == 2) begin
            check("full_w0", mus_log[0], 32'h0000_0201);
            check("full_w1", mus_log[1], 32'h0001_0403);
        end
        check("full_len", 32'(last_len), 32'd6);

        // Sprite address boundary
        clear_logs();
        start(8'd3);
        wbyte(25'h8000, 8'h77, 0);
        wbyte(25'h7FFF, 8'h5A, 0);
        finish_session(50);
        check("spr_cnt", 32'(spr_log.size()), 32'd1);
        if (spr_log.size() == 1) check("spr_w", spr_log[0], 32'h007F_FF5A);
        check("spr_ovf", 32'(overflow), 32'd1);

        // Unrouted slot
        clear_logs();
        start(8'd7);
        for (int i = 0; i < 5; i++) wbyte(25'(i), 8'($urandom), 0);
        finish_session(50);
        check("idx7_writes", 32'(bios_log.size() + spr_log.size() + mus_log.size()), 32'd0);
        check("idx7_len", 32'(last_len), 32'd5);
        check("idx7_ovf", 32'(overflow), 32'd0);

        // Reset in the middle of a music session with one word queued
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        ack_mode = 0;
        start(8'd4);
        wbyte(25'd0, 8'h12, 0); wbyte(25'd1, 8'h34, 0);
        tick();
        check("abort_req_before", 32'(mus_req), 32'd1);
        reset_n = 1'b0; dn_download = 1'b0;
        tick();
        check("abort_req", 32'(mus_req), 32'd0);
        check("abort_len", 32'(last_len), 32'd0);
        reset_n = 1'b1;
        repeat (8) tick();

        // Randomized sessions
        for (int s = 0; s < 16; s++) begin
            sel = $urandom_range(0, 4);
            n   = $urandom_range(1, 20);
            case (sel)
                0: begin idx = 8'd0; base = ($urandom_range(0, 2) == 0) ? 25'd16381 : 25'($urandom_range(0, 2000)); end
                1: begin idx = 8'd3; base = ($urandom_range(0, 2) == 0) ? 25'd32765 : 25'($urandom_range(0, 2000)); end
                2: begin idx = 8'd4; base = ($urandom_range(0, 2) == 0) ? 25'h1_FFFA : 25'(2 * $urandom_range(0, 5000)); end
                3: begin idx = 8'd7; base = 25'($urandom); end
                default: begin idx = 8'($urandom); base = 25'($urandom_range(0, 40000)); end
            endcase
            ack_mode = $urandom_range(1, 2);
            start(idx);
            dn_index = 8'($urandom);
            for (int i = 0; i < n; i++) wbyte(base + 25'(i), 8'($urandom), $urandom_range(0, 2));
            finish_session(200);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
